// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if
//   Request/response bundle between the control unit and the HI/LO
//   multiply/divide unit.
//   master : control unit side. It drives the start/move/read requests and
//            the operands, and receives busy, stall, rdata, hi and lo.
//   slave  : muldiv_hilo side. The directions are the reverse of master.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start_mult;
  logic             start_multu;
  logic             start_div;
  logic             start_divu;
  logic             mthi;
  logic             mtlo;
  logic             mfhi;
  logic             mflo;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, start_multu, start_div, start_divu,
    output mthi, mtlo, mfhi, mflo, a, b,
    input  busy, stall, rdata, hi, lo
  );

  modport slave (
    input  start_mult, start_multu, start_div, start_divu,
    input  mthi, mtlo, mfhi, mflo, a, b,
    output busy, stall, rdata, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo.sv
// muldiv_hilo
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   Multiply uses radix-2 shift-add. Divide uses restoring shift-subtract
//   on operand magnitudes. Both run for WIDTH iterations, followed by one
//   sign-fix/write-back cycle.
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_hilo_if.slave
//           inputs : start_mult/multu/div/divu, mthi, mtlo, mfhi, mflo, a, b
//           outputs: busy, stall, rdata (HI/LO read mux), hi, lo
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_hilo_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t             state_r, state_nx_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;      // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_r;     // multiplicand magnitude (mult) or divisor magnitude (div)
  logic [WIDTH-1:0]   a_raw_r;    // unmodified dividend, returned in HI on divide-by-zero
  logic               is_div_r;
  logic               neg_res_r;  // product/quotient must be negated
  logic               neg_rem_r;  // remainder must be negated (dividend was negative)
  logic               div_zero_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               any_start_s, sel_div_s, sel_signed_s;
  logic [WIDTH-1:0]   abs_a_s, abs_b_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s;
  logic [2*WIDTH-1:0] mul_next_s, div_next_s, prod_s;
  logic [WIDTH-1:0]   fix_hi_s, fix_lo_s, rdata_s;

  assign any_start_s = bus.start_mult | bus.start_multu | bus.start_div | bus.start_divu;

  // Request priority: mult > multu > div > divu.
  always_comb begin
    sel_div_s    = 1'b0;
    sel_signed_s = 1'b0;
    if (bus.start_mult) begin
      sel_div_s    = 1'b0;
      sel_signed_s = 1'b1;
    end else if (bus.start_multu) begin
      sel_div_s    = 1'b0;
      sel_signed_s = 1'b0;
    end else if (bus.start_div) begin
      sel_div_s    = 1'b1;
      sel_signed_s = 1'b1;
    end else if (bus.start_divu) begin
      sel_div_s    = 1'b1;
      sel_signed_s = 1'b0;
    end else begin
      sel_div_s    = 1'b0;
      sel_signed_s = 1'b0;
    end
  end

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  assign abs_a_s = (sel_signed_s && bus.a[WIDTH-1]) ? neg_w(bus.a) : bus.a;
  assign abs_b_s = (sel_signed_s && bus.b[WIDTH-1]) ? neg_w(bus.b) : bus.b;

  // One shift-add step (carry kept) and one restoring shift-subtract step.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opnd_r};
    if (div_trial_s[WIDTH]) begin
      div_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction and HI/LO selection for the FIX cycle.
  always_comb begin
    prod_s   = neg_res_r ? neg_2w(acc_r) : acc_r;
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (!is_div_r) begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end else if (div_zero_r) begin
      fix_hi_s = a_raw_r;
      fix_lo_s = {WIDTH{1'b1}};
    end else begin
      fix_hi_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      fix_lo_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_start_s) begin
          state_nx_s = CALC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = FIX;
        end else begin
          state_nx_s = CALC;
        end
      end
      FIX:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: operand capture, iterations, HI/LO write-back and moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CW{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      opnd_r     <= {WIDTH{1'b0}};
      a_raw_r    <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      hi_r       <= {WIDTH{1'b0}};
      lo_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_start_s) begin
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {{WIDTH{1'b0}}, (sel_div_s ? abs_a_s : abs_b_s)};
            opnd_r     <= sel_div_s ? abs_b_s : abs_a_s;
            a_raw_r    <= bus.a;
            is_div_r   <= sel_div_s;
            neg_res_r  <= sel_signed_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_r  <= sel_signed_s & bus.a[WIDTH-1];
            div_zero_r <= sel_div_s & (bus.b == {WIDTH{1'b0}});
          end else begin
            // A start in the same cycle takes priority, so moves live here.
            if (bus.mthi) hi_r <= bus.a;
            if (bus.mtlo) lo_r <= bus.a;
          end
        end
        CALC: begin
          acc_r <= is_div_r ? div_next_s : mul_next_s;
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          hi_r <= fix_hi_s;
          lo_r <= fix_lo_s;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // HI/LO read mux.
  always_comb begin
    rdata_s = {WIDTH{1'b0}};
    if (bus.mfhi) begin
      rdata_s = hi_r;
    end else if (bus.mflo) begin
      rdata_s = lo_r;
    end else begin
      rdata_s = {WIDTH{1'b0}};
    end
  end

  assign bus.busy  = (state_r != IDLE);
  assign bus.stall = bus.busy & (any_start_s | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo);
  assign bus.rdata = rdata_s;
  assign bus.hi    = hi_r;
  assign bus.lo    = lo_r;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo
//   Directed scoreboard bench for muldiv_hilo. Each started operation pushes
//   its hand-computed {HI, LO} into a queue. A monitor pops one entry and
//   compares it whenever busy falls outside reset.
module tb_muldiv_hilo;
  localparam int W = 32;
  localparam int OP_MULT  = 0;
  localparam int OP_MULTU = 1;
  localparam int OP_DIV   = 2;
  localparam int OP_DIVU  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  muldiv_hilo_if #(.WIDTH(W)) bus ();
  muldiv_hilo #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          tests_run = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];
  bit          prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a falling busy (outside reset) presents a result.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !bus.busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {bus.hi, bus.lo}, 64'h0);
          chk("unexpected_result_queue", 64'(exp_q.size()), 64'd1);
        end else begin
          chk(name_q.pop_front(), {bus.hi, bus.lo}, exp_q.pop_front());
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    bus.start_mult = 1'b0; bus.start_multu = 1'b0;
    bus.start_div  = 1'b0; bus.start_divu  = 1'b0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mfhi = 1'b0; bus.mflo = 1'b0;
    bus.a = 32'h0; bus.b = 32'h0;
  endtask

  task automatic start_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input string nm, input bit expect_result);
    @(posedge clk); #1;
    bus.a = a;
    bus.b = b;
    case (op)
      OP_MULT:  bus.start_mult  = 1'b1;
      OP_MULTU: bus.start_multu = 1'b1;
      OP_DIV:   bus.start_div   = 1'b1;
      default:  bus.start_divu  = 1'b1;
    endcase
    if (expect_result) begin
      exp_q.push_back({eh, el});
      name_q.push_back(nm);
    end
    @(posedge clk); #1;
    bus.start_mult = 1'b0; bus.start_multu = 1'b0;
    bus.start_div  = 1'b0; bus.start_divu  = 1'b0;
  endtask

  // Counts busy cycles until busy drops, bounded at 100 cycles.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int n;
    start_op(op, a, b, eh, el, nm, 1'b1);
    wait_done(n);
    chk({nm, "_busy_cycles"}, 64'(n), 64'd33);
  endtask

  initial begin
    int stalled;
    int not_stalled;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("reset_rdata", {32'h0, bus.rdata}, 64'h0);
    bus.mfhi = 1'b1;
    #1;
    chk("reset_stall", 64'(bus.stall), 64'd0);
    bus.mfhi = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7");
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
    run_op(OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, "divu_big");
    run_op(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2");
    run_op(OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, "divu_by0");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_overflow");

    // A dependent mflo is stalled while busy, then reads the new LO.
    start_op(OP_MULTU, 32'h00012345, 32'h00000010, 32'h00000000, 32'h00123450, "multu_stall", 1'b1);
    repeat (4) @(posedge clk);
    #1;
    bus.mflo = 1'b1;
    stalled = 0;
    not_stalled = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (bus.stall) stalled++;
      else not_stalled++;
    end
    chk("mflo_stalled_cycles", 64'(stalled), 64'd29);
    chk("mflo_unstalled_while_busy", 64'(not_stalled), 64'd0);
    chk("mflo_stall_after_done", 64'(bus.stall), 64'd0);
    chk("mflo_rdata", {32'h0, bus.rdata}, {32'h0, 32'h00123450});
    @(posedge clk); #1;
    bus.mflo = 1'b0;

    // Moves while idle.
    bus.a = 32'hCAFEF00D;
    bus.mthi = 1'b1;
    @(negedge clk);
    chk("mthi_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    bus.mfhi = 1'b1;
    @(negedge clk);
    chk("mthi_hilo", {bus.hi, bus.lo}, {32'hCAFEF00D, 32'h00123450});
    chk("mfhi_rdata", {32'h0, bus.rdata}, {32'h0, 32'hCAFEF00D});
    @(posedge clk); #1;
    bus.mfhi = 1'b0;
    bus.a = 32'h0BADF00D;
    bus.mtlo = 1'b1;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    bus.mflo = 1'b1;
    @(negedge clk);
    chk("mtlo_hilo", {bus.hi, bus.lo}, {32'hCAFEF00D, 32'h0BADF00D});
    chk("mflo_rdata_move", {32'h0, bus.rdata}, {32'h0, 32'h0BADF00D});
    @(posedge clk); #1;
    bus.mflo = 1'b0;
    @(negedge clk);
    chk("rdata_no_select", {32'h0, bus.rdata}, 64'h0);

    // Reset in the middle of a multiply: no result expected.
    start_op(OP_MULT, 32'h00000005, 32'h00000006, 32'h0, 32'h0, "mult_aborted", 1'b0);
    repeat (9) @(posedge clk);
    #2;
    chk("midop_busy_before_reset", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_reset_busy", 64'(bus.busy), 64'd0);
    chk("midop_reset_hilo", {bus.hi, bus.lo}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(OP_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, "multu_3x4");

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit with the HI/LO register pair. It executes the mult, multu, div, divu, mthi, mtlo, mfhi and mflo operations that the control unit decodes, and sits beside the ALU in the execute stage. It stalls the front end while a 32-step operation is in flight.

## Interface
- `WIDTH`, default 32: operand width. HI/LO are each WIDTH bits. The iteration count equals WIDTH.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start_mult`, input, 1: signed multiply request, one-cycle level.
- `start_multu`, input, 1: unsigned multiply request.
- `start_div`, input, 1: signed divide request.
- `start_divu`, input, 1: unsigned divide request.
- `mthi`, input, 1: write `a` into HI.
- `mtlo`, input, 1: write `a` into LO.
- `mfhi`, input, 1: select HI onto `rdata`.
- `mflo`, input, 1: select LO onto `rdata`.
- `a`, input, WIDTH: rs operand (multiplicand/dividend, or move-to data).
- `b`, input, WIDTH: rt operand (multiplier/divisor).
- `busy`, output, 1: an operation is in flight.
- `stall`, output, 1: the current request cannot be serviced; upstream must hold the instruction.
- `rdata`, output, WIDTH: HI when `mfhi`, LO when `mflo`, otherwise 0.
- `hi`, output, WIDTH: current HI register.
- `lo`, output, WIDTH: current LO register.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - A start request latches `a`, `b`, the op kind and the signs, takes absolute values for signed ops, clears the iteration counter and moves to CALC.
  - If multiple start inputs are high, priority is mult > multu > div > divu. Only one start is legal; the decoder guarantees this.
  - A start in the same cycle as `mthi`/`mtlo` wins; the move is dropped.
- **CALC:** one iteration per cycle, WIDTH iterations, counter 0..WIDTH-1.
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, giving a WIDTH-bit quotient and a WIDTH-bit remainder.
  - After iteration WIDTH-1, go to FIX.
- **FIX:** sign correction, then write HI/LO, then return to IDLE.
  - Signed mult: negate the 64-bit product if sign(a) ^ sign(b).
  - Signed div: quotient negated if sign(a) ^ sign(b); remainder takes the sign of `a`.
  - Multiply result: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide result: LO = quotient, HI = remainder.
- **Divide by zero** (b == 0, signed or unsigned):
  - LO = all ones; HI = `a` unmodified.
  - No sign fix is applied. No exception is raised.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **`mthi`/`mtlo`:** act only in IDLE; HI (or LO) takes `a` on the edge.
- **`rdata`:** combinational from the current HI/LO. It returns stale data if read while busy, but the read is stalled (see below).
- **Stall rule:** `stall = busy & (any start | mthi | mtlo | mfhi | mflo)`.
  - Requests presented while busy are ignored internally.
  - The same instruction is re-presented once `stall` drops.

## Timing
- **Reset:** state IDLE, `busy` = 0, `stall` = 0, HI = 0, LO = 0, `rdata` = 0, counter and accumulators 0.
- **Start accept:** on edge E0 while IDLE.
  - `busy` is high from after E0 until after edge E0+WIDTH+1, i.e. WIDTH+1 cycles (33 for WIDTH = 32): WIDTH CALC cycles plus one FIX cycle.
  - HI/LO update on edge E0+WIDTH+1. On the same edge `busy` falls.
  - A dependent `mfhi` presented in any busy cycle is stalled, then reads the new value in the first cycle `busy` = 0.
- **Back-to-back:** a start may be accepted on the very edge `busy` falls is NOT allowed, because the unit is still in FIX. The earliest next accept is the cycle after `busy` = 0 is visible, giving zero idle bubbles from the consumer's view.
- **`mthi`/`mtlo`:** single-cycle; visible on `hi`/`lo` the cycle after the edge.
- **Reset mid-operation:** abandons the operation immediately; no partial HI/LO write.

## Test plan
- **Signed multiply:** `mult` a = 0xFFFFFFFD (-3), b = 7.
  - `busy` is high for exactly 33 cycles.
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- **Unsigned multiply:** `multu` a = 0xFFFFFFFF, b = 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- **Signed divide:**
  - `div` a = -7 (0xFFFFFFF9), b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - `divu` with the same operands → LO = 0x7FFFFFFC, HI = 0x00000001.
- **Divide edge cases:**
  - `divu` a = 0x1234, b = 0 → LO = 0xFFFFFFFF, HI = 0x1234.
  - `div` 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Stall and moves:**
  - `mflo` issued 5 cycles after a start: `stall` = 1 until `busy` falls, then `rdata` equals the new LO.
  - `mthi` a = 0xCAFEF00D while idle: `hi` = 0xCAFEF00D next cycle and `stall` stays 0.
- **Reset mid-operation:** assert `rst_n` = 0 at cycle 10 of a `mult`. `busy`, HI and LO go to 0 asynchronously; after release a new `multu` 3 × 4 gives LO = 12.
